// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU command sequencer: add/sub/and passes plus radix-2 Booth multiply.
// Optional macro SEQ_SKIP_NOP_EN bypasses Booth passes whose q1/q0 pair calls for no ALU action.
module serial_alu_sequencer #(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [5:0] cmd_len,
  input  logic       mul_lsb,
  output logic [3:0] alu_sel,
  output logic [5:0] length,
  output logic [6:0] count,
  output logic [5:0] bit_idx,
  output logic       reg_write,
  output logic       q0_var,
  output logic       q1_var,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [5:0] MaxLen = 6'(MAX_LEN);
  localparam logic [3:0] OpMul  = 4'd2;

`ifdef SEQ_SKIP_NOP_EN
  localparam bit SkipNop = 1'b1;
`else
  localparam bit SkipNop = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PASS, SHIFT, FLUSH} state_t;

  state_t     state;
  logic [5:0] iter;

  logic [5:0] len_clamped;
  logic       op_legal;
  logic       last_bit;
  logic [5:0] iter_next;
  logic       last_iter;
  logic       pass_q0;
  logic       skip_pass;

  assign len_clamped = (cmd_len > MaxLen) ? MaxLen : cmd_len;
  assign op_legal    = (cmd_op == 4'd0) || (cmd_op == 4'd1) || (cmd_op == 4'd2) || (cmd_op == 4'd4);
  assign last_bit    = (bit_idx == length - 6'd1);
  assign iter_next   = iter + 6'd1;
  assign last_iter   = (iter_next == length);

  // q1_var still holds the multiplier bit of the pass just finished, so it becomes the next q0.
  assign pass_q0   = (state == SHIFT) ? q1_var : 1'b0;
  assign skip_pass = SkipNop && (mul_lsb == pass_q0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      iter      <= '0;
      cmd_ready <= 1'b0;
      alu_sel   <= '0;
      length    <= '0;
      count     <= '0;
      bit_idx   <= '0;
      reg_write <= 1'b0;
      q0_var    <= 1'b0;
      q1_var    <= 1'b0;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      shift_en <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          count     <= '0;
          bit_idx   <= '0;
          reg_write <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            alu_sel   <= cmd_op;
            length    <= len_clamped;
            iter      <= '0;
            if (len_clamped == 6'd0 || !op_legal) begin
              state <= FLUSH;
              count <= {len_clamped, 1'b0} + 7'd2;
              done  <= 1'b1;
              err   <= !op_legal;
            end else if (cmd_op == OpMul) begin
              q1_var <= mul_lsb;
              q0_var <= pass_q0;
              if (skip_pass) begin
                state    <= SHIFT;
                shift_en <= 1'b1;
              end else begin
                state     <= PASS;
                reg_write <= (mul_lsb != pass_q0);
              end
            end else begin
              state     <= PASS;
              reg_write <= 1'b1;
            end
          end
        end

        PASS: begin
          if (last_bit) begin
            bit_idx   <= '0;
            reg_write <= 1'b0;
            if (alu_sel == OpMul) begin
              state    <= SHIFT;
              count    <= '0;
              shift_en <= 1'b1;
            end else begin
              state <= FLUSH;
              count <= {length, 1'b0} + 7'd2;
              done  <= 1'b1;
            end
          end else begin
            count   <= count + 7'd1;
            bit_idx <= bit_idx + 6'd1;
          end
        end

        // The register file shifts on this edge; the bit it presents now seeds the next pass.
        SHIFT: begin
          iter <= iter_next;
          if (last_iter) begin
            state <= FLUSH;
            count <= {length, 1'b0} + 7'd2;
            done  <= 1'b1;
          end else begin
            q1_var <= mul_lsb;
            q0_var <= pass_q0;
            count  <= '0;
            if (skip_pass) begin
              state    <= SHIFT;
              shift_en <= 1'b1;
            end else begin
              state     <= PASS;
              reg_write <= (mul_lsb != pass_q0);
            end
          end
        end

        FLUSH: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          count     <= '0;
          bit_idx   <= '0;
          reg_write <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer: vector table through a done-driven scoreboard,
// plus hand sequences for Booth q pairs, back-to-back accept and mid-operation reset.
module tb_serial_alu_sequencer;

`ifdef SEQ_SKIP_NOP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [5:0] cmd_len;
  logic       mul_lsb = 1'b0;
  logic [3:0] alu_sel;
  logic [5:0] length;
  logic [6:0] count;
  logic [5:0] bit_idx;
  logic       reg_write;
  logic       q0_var;
  logic       q1_var;
  logic       shift_en;
  logic       busy;
  logic       done;
  logic       err;

  serial_alu_sequencer #(.MAX_LEN(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .mul_lsb(mul_lsb), .alu_sel(alu_sel),
    .length(length), .count(count), .bit_idx(bit_idx), .reg_write(reg_write),
    .q0_var(q0_var), .q1_var(q1_var), .shift_en(shift_en), .busy(busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  len;
    logic [63:0] seq;
    int          lat;
    int          lat_skip;
    bit          err;
    int          cnt;
    int          wr;
    int          sh;
    int          l;
  } vec_t;

  typedef struct {
    int lat;
    bit err;
    int cnt;
    int wr;
    int sh;
    int l;
  } exp_t;

  vec_t        vecs[12];
  exp_t        sb[$];
  logic [1:0]  pair_q[$];
  exp_t        cur_e;
  logic [63:0] cur_seq = 64'd0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int prev_accept = 0;
  int accept_cnt = 0;
  int seen_cnt = 0;
  int writes = 0;
  int shifts = 0;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Accepts are seen on the active edge, before the DUT's own registers update.
  always @(posedge clk) begin
    if (reset && cmd_valid && cmd_ready) begin
      prev_accept = accept_cyc;
      accept_cyc  = cyc;
      accept_cnt++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (accept_cnt != seen_cnt) begin
        seen_cnt = accept_cnt;
        writes   = 0;
        shifts   = 0;
      end
      if (reg_write) begin
        if (sb.size() > 0 && sb[0].l > 0) begin
          check_output("bit_idx", int'(bit_idx), writes % sb[0].l);
          check_output("count_pass", int'(count), int'(bit_idx));
        end
        writes++;
      end
      if (shift_en) begin
        shifts++;
        pair_q.push_back({q1_var, q0_var});
      end
      if (err) check_output("err_with_done", int'(done), 1);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 expected no pending command");
        end else begin
          cur_e = sb.pop_front();
          check_output("latency", cyc - accept_cyc, cur_e.lat);
          check_output("err", int'(err), int'(cur_e.err));
          check_output("flush_count", int'(count), cur_e.cnt);
          check_output("writes", writes, cur_e.wr);
          check_output("shifts", shifts, cur_e.sh);
          check_output("length", int'(length), cur_e.l);
          check_output("ready_in_flush", int'(cmd_ready), 0);
          check_output("busy_in_flush", int'(busy), 1);
        end
      end
      mul_lsb = busy ? cur_seq[shifts] : cur_seq[0];
    end
  end

  task automatic wait_accept(input int n);
    int k;
    k = 0;
    while (accept_cnt == n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (accept_cnt == n) check_output("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < bound) begin
      @(negedge clk); #1;
      k++;
    end
    if (sb.size() != 0 || busy) begin
      check_output("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.lat = Skip ? v.lat_skip : v.lat;
    e.err = v.err;
    e.cnt = v.cnt;
    e.wr  = v.wr;
    e.sh  = v.sh;
    e.l   = v.l;
    return e;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    int n;
    @(negedge clk); #1;
    cmd_op  = v.op;
    cmd_len = v.len;
    cur_seq = v.seq;
    @(negedge clk); #1;
    n = accept_cnt;
    sb.push_back(to_exp(v));
    cmd_valid = 1'b1;
    wait_accept(n);
    cmd_valid = 1'b0;
    wait_idle(3000);
  endtask

  initial begin
    exp_t e2;
    int   n;
    int   k;
    logic [1:0] want_pairs[4];

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
    //          op    len    seq      lat lat_skip err cnt wr  sh  l
    vecs[0]  = '{4'd0, 6'd8,  64'h0,  9,  9,  1'b0, 18, 8,  0,  8};
    vecs[1]  = '{4'd1, 6'd4,  64'h0,  5,  5,  1'b0, 10, 4,  0,  4};
    vecs[2]  = '{4'd4, 6'd5,  64'h0,  6,  6,  1'b0, 12, 5,  0,  5};
    vecs[3]  = '{4'd3, 6'd8,  64'h0,  1,  1,  1'b1, 18, 0,  0,  8};
    vecs[4]  = '{4'd0, 6'd0,  64'h0,  1,  1,  1'b0, 2,  0,  0,  0};
    vecs[5]  = '{4'd0, 6'd40, 64'h0,  33, 33, 1'b0, 66, 32, 0,  32};
    vecs[6]  = '{4'd7, 6'd3,  64'h0,  1,  1,  1'b1, 8,  0,  0,  3};
    vecs[7]  = '{4'd2, 6'd4,  64'h9,  21, 17, 1'b0, 10, 12, 4,  4};
    vecs[8]  = '{4'd2, 6'd3,  64'h0,  13, 4,  1'b0, 8,  0,  3,  3};
    vecs[9]  = '{4'd2, 6'd1,  64'h1,  3,  3,  1'b0, 4,  1,  1,  1};
    vecs[10] = '{4'd1, 6'd63, 64'h0,  33, 33, 1'b0, 66, 32, 0,  32};
    vecs[11] = '{4'd2, 6'd5,  64'h16, 31, 21, 1'b0, 12, 15, 5,  5};

    #3;
    check_output("reset_outputs",
                 int'({alu_sel, length, count, bit_idx, reg_write, q0_var, q1_var, shift_en, busy, done, err}), 0);
    check_output("reset_ready", int'(cmd_ready), 0);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check_output("ready_after_reset", int'(cmd_ready), 1);
    check_output("idle_busy", int'(busy), 0);
    check_output("idle_count", int'(count), 0);

    for (int i = 0; i < 12; i++) apply_stimulus(vecs[i]);
    check_output("alu_sel_holds", int'(alu_sel), 2);
    check_output("idle_bit_idx", int'(bit_idx), 0);

    // Booth pairs for multiplier bits 1,0,0,1 (skipped pass still shows its pair in SHIFT).
    pair_q.delete();
    apply_stimulus(vecs[7]);
    want_pairs[0] = 2'b10; want_pairs[1] = 2'b01; want_pairs[2] = 2'b00; want_pairs[3] = 2'b10;
    check_output("pair_count", pair_q.size(), 4);
    for (int i = 0; i < 4 && i < pair_q.size(); i++) check_output("q1q0_pair", int'(pair_q[i]), int'(want_pairs[i]));

    // Back-to-back: command held valid, fields changed while busy must not matter.
    @(negedge clk); #1;
    cmd_op = 4'd1; cmd_len = 6'd4; cur_seq = 64'h0;
    @(negedge clk); #1;
    n = accept_cnt;
    sb.push_back(to_exp(vecs[1]));
    cmd_valid = 1'b1;
    wait_accept(n);
    cmd_op = 4'd0; cmd_len = 6'd3;
    e2 = '{4, 1'b0, 8, 3, 0, 3};
    sb.push_back(e2);
    k = 0;
    while (sb.size() > 1 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check_output("b2b_first_done", sb.size(), 1);
    @(negedge clk); #1;
    check_output("b2b_ready_after_flush", int'(cmd_ready), 1);
    wait_accept(n + 1);
    check_output("b2b_accept_gap", accept_cyc - prev_accept, 6);
    cmd_valid = 1'b0;
    wait_idle(100);

    // Reset dropped during pass 2, bit 1 of a multiply.
    @(negedge clk); #1;
    cmd_op = 4'd2; cmd_len = 6'd4; cur_seq = 64'h9;
    @(negedge clk); #1;
    n = accept_cnt;
    sb.push_back(to_exp(vecs[7]));
    cmd_valid = 1'b1;
    wait_accept(n);
    cmd_valid = 1'b0;
    k = 0;
    while (!(shifts == 1 && reg_write && bit_idx == 6'd1) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check_output("reached_pass2_bit1", int'(bit_idx), 1);
    reset = 1'b0;
    #1;
    check_output("async_reset_outputs",
                 int'({alu_sel, length, count, bit_idx, reg_write, q0_var, q1_var, shift_en, busy, done, err}), 0);
    check_output("async_reset_ready", int'(cmd_ready), 0);
    sb.delete();
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_output("held_reset_done", int'(done), 0);
    reset = 1'b1;
    @(negedge clk); #1;
    check_output("ready_after_release", int'(cmd_ready), 1);
    apply_stimulus('{4'd0, 6'd6, 64'h0, 7, 7, 1'b0, 14, 6, 0, 6});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
